adc_spi_capture: RTL and testbench
==================================

// Module: adc_spi_capture
// PURPOSE
//  Upstream feeder for the 4-channel averaging stage. SPI master that scans a 4-channel serial ADC round-robin.
//  Each converted sample is widened to OUT_W and presented on data_outN with a one-cycle data_en strobe.
//  These outputs wire directly to the averager's data_inN/dataN_en inputs.
// PARAMETERS
//  SAMPLE_W  16  ADC word length = SCLK cycles per frame (>=4)
//  OUT_W     32  output word width (>= SAMPLE_W); matches averager DATAn_W
//  CLK_DIV    4  clk cycles per SCLK half-period (>=1)
//  CONV_GAP   8  clk cycles cs_n held high between frames (>=1)
// PORTS
//  clk         in   1        system clock, all logic on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  scan_en     in   1        1 = scan continuously; 0 = stop after current frame
//  adc_sclk    out  1        SPI clock, idle low (CPOL=0)
//  adc_cs_n    out  1        SPI chip select, active low
//  adc_mosi    out  1        command bit, MSB first
//  adc_miso    in   1        ADC data, MSB first
//  data_out0..3 out OUT_W    last sample of channel 0..3, held until next update
//  data0_en..3_en out 1      one-cycle strobe, data_outN valid on the same cycle
//  busy        out  1        high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, takes effect immediately, including mid-frame):
//   adc_sclk=0, adc_cs_n=1, adc_mosi=0, data_out*=0, data*_en=0, busy=0, channel pointer=0, state=IDLE.
//  FSM:
//   IDLE  -> SETUP when scan_en=1.
//   SETUP: CLK_DIV cycles, cs_n=0, sclk=0, mosi = cmd MSB.
//   SHIFT: 2*CLK_DIV*SAMPLE_W cycles. sclk toggles every CLK_DIV cycles.
//    adc_miso is sampled into the shift register on the clk cycle sclk goes 0->1.
//    mosi advances on each 1->0 sclk transition.
//   HOLD: CLK_DIV cycles, sclk=0, cs_n=0. On the first HOLD cycle, data_outN is updated and dataN_en=1 for N = channel pointer.
//   GAP: CONV_GAP cycles, cs_n=1. On exit, the pointer increments mod 4 (3 -> 0); the next state is SETUP if scan_en=1, else IDLE.
//  Command word = {ch[1:0], {(SAMPLE_W-2){1'b0}}}. The ADC returns the addressed channel in the same frame.
//  Frame period = CLK_DIV*(2*SAMPLE_W+2)+CONV_GAP clk cycles. With defaults this is 144; a full 4-channel scan takes 576.
//  scan_en falling mid-frame: the frame completes, its strobe fires, and the block enters IDLE after GAP.
//   The pointer is kept, so the scan resumes at the next channel.
//  scan_en toggling while in GAP: it is sampled only on the last GAP cycle.
//  At most one data*_en is high in any cycle. data_out of the other channels is unchanged.
//  Width: sample bits [SAMPLE_W-1:0] map to data_outN[SAMPLE_W-1:0]. Upper bits follow CONFIGURATION.
// CONFIGURATION
//  ADC_SIGN_EXTEND_EN defined:
//   Upper OUT_W-SAMPLE_W bits replicate sample bit SAMPLE_W-1 (two's-complement ADC).
//  ADC_SIGN_EXTEND_EN undefined (default):
//   Upper bits are zero (offset-binary ADC). This keeps the averager's unsigned accumulation correct.
// STRUCTURE
//  Package adc_capture_pkg:
//   state encoding localparams (IDLE, SETUP, SHIFT, HOLD, GAP)
//   NUM_CH=4, CH_W=2
//   cmd-word field positions
//  Sub-module spi_shift_engine (SAMPLE_W, CLK_DIV):
//   generates sclk, runs the mosi/miso shift registers, raises a done pulse.
//   The top level owns the FSM, channel pointer, widening and the output registers.
// TESTING
//  1 Reset then scan_en=1; the ADC model returns 16'h1234, 16'h8001, 16'h00FF, 16'hFFFF on ch0..3.
//    -> data0_en..3_en fire in order, 144 cycles apart.
//    -> data_out = 32'h00001234, 32'h00008001, 32'h000000FF, 32'h0000FFFF.
//  2 Same stimulus with ADC_SIGN_EXTEND_EN defined.
//    -> data_out1 = 32'hFFFF8001, data_out3 = 32'hFFFFFFFF, data_out0 = 32'h00001234.
//  3 Monitor the SPI pins.
//    -> sclk high/low exactly 4 cycles each, 16 rising edges per cs_n-low window.
//    -> mosi bits 15:14 = channel, other bits 0.
//    -> cs_n high for >= 8 cycles between frames.
//  4 Drop scan_en during ch1 SHIFT.
//    -> the ch1 strobe still fires, then IDLE, busy=0.
//    -> On re-enable, the first frame addresses ch2.
//  5 Assert rst_n=0 mid-SHIFT of ch2.
//    -> In the same cycle: cs_n=1, sclk=0, data_out*=0, no strobe.
//    -> After release with scan_en=1, the next frame addresses ch0.
//  6 Run scan_en=1 for 10 scans.
//    -> Strobe-overlap checker: never more than one dataN_en high in a cycle.
//    -> Strobe count per channel = 10.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared definitions for the round-robin ADC capture block: FSM encoding,
// channel count and the position of the channel field in the command word.
package adc_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    // Channel field sits at the top of the command word, counted down from its MSB.
    localparam int CMD_CH_MSB_OFS = 0;
    localparam int CMD_CH_LSB_OFS = CH_W - 1;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: divides clk into sclk, shifts the command out on mosi,
// captures miso on sclk rising transitions and flags the last cycle of a frame.
module spi_shift_engine #(
    parameter int SAMPLE_W = 16,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                run,
    input  logic [SAMPLE_W-1:0] cmd,
    input  logic                miso,
    output logic                sclk,
    output logic                mosi,
    output logic                done,
    output logic [SAMPLE_W-1:0] rx_data
);

    localparam int DIV_W  = $clog2(CLK_DIV) + 1;
    localparam int HALF_W = $clog2(2 * SAMPLE_W) + 1;

    logic [DIV_W-1:0]    div_q, div_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic                sclk_q, sclk_d;
    logic [SAMPLE_W-1:0] tx_q, tx_d;
    logic [SAMPLE_W-1:0] rx_q, rx_d;

    always_comb begin
        // NOTE: every _d starts from its _q (and done from 0) so no branch can infer a latch.
        div_d  = div_q;
        half_d = half_q;
        sclk_d = sclk_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        done   = 1'b0;
        if (load) begin
            div_d  = '0;
            half_d = '0;
            sclk_d = 1'b0;
            tx_d   = cmd;
        end else if (run) begin
            if (div_q == DIV_W'(CLK_DIV - 1)) begin
                div_d  = '0;
                sclk_d = ~sclk_q;
                half_d = half_q + HALF_W'(1);
                // Rising transition captures miso, falling transition advances mosi.
                if (!sclk_q) rx_d = {rx_q[SAMPLE_W-2:0], miso};
                else         tx_d = {tx_q[SAMPLE_W-2:0], 1'b0};
                done = (half_q == HALF_W'(2 * SAMPLE_W - 1));
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            half_q <= '0;
            sclk_q <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else begin
            div_q  <= div_d;
            half_q <= half_d;
            sclk_q <= sclk_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = tx_q[SAMPLE_W-1];
    assign rx_data = rx_q;

endmodule

// File: rtl/adc_spi_capture.sv
// Round-robin 4-channel SPI ADC scanner feeding the averager's data_inN/dataN_en inputs.
// Define ADC_SIGN_EXTEND_EN for a two's-complement ADC; default zero-extends (offset binary).
module adc_spi_capture
    import adc_capture_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int OUT_W    = 32,
    parameter int CLK_DIV  = 4,
    parameter int CONV_GAP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_en,
    output logic             adc_sclk,
    output logic             adc_cs_n,
    output logic             adc_mosi,
    input  logic             adc_miso,
    output logic [OUT_W-1:0] data_out0,
    output logic [OUT_W-1:0] data_out1,
    output logic [OUT_W-1:0] data_out2,
    output logic [OUT_W-1:0] data_out3,
    output logic             data0_en,
    output logic             data1_en,
    output logic             data2_en,
    output logic             data3_en,
    output logic             busy
);

    localparam int CNT_MAX = (CLK_DIV > CONV_GAP) ? CLK_DIV : CONV_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [OUT_W-1:0]    data_q [NUM_CH];
    logic [OUT_W-1:0]    data_d [NUM_CH];
    logic [NUM_CH-1:0]   en_q, en_d;

    logic                eng_load, eng_run, eng_done, eng_sclk, eng_mosi;
    logic [SAMPLE_W-1:0] cmd_word, rx_data;
    logic [OUT_W-1:0]    sample_wide;

    always_comb begin
        cmd_word = '0;
        cmd_word[SAMPLE_W-1-CMD_CH_MSB_OFS : SAMPLE_W-1-CMD_CH_LSB_OFS] = ch_q;
    end

`ifdef ADC_SIGN_EXTEND_EN
    assign sample_wide = OUT_W'($signed(rx_data));
`else
    assign sample_wide = OUT_W'(rx_data);
`endif

    spi_shift_engine #(
        .SAMPLE_W (SAMPLE_W),
        .CLK_DIV  (CLK_DIV)
    ) u_engine (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (eng_load),
        .run     (eng_run),
        .cmd     (cmd_word),
        .miso    (adc_miso),
        .sclk    (eng_sclk),
        .mosi    (eng_mosi),
        .done    (eng_done),
        .rx_data (rx_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        ch_d    = ch_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (scan_en) state_d = ST_SETUP;
            end
            ST_SETUP: if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
            end
            ST_SHIFT: begin
                cnt_d = '0;
                if (eng_done) state_d = ST_HOLD;
            end
            ST_HOLD: if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
            ST_GAP: if (cnt_q == CNT_W'(CONV_GAP - 1)) begin
                // scan_en only matters here, so toggles earlier in GAP are ignored.
                state_d = scan_en ? ST_SETUP : ST_IDLE;
                cnt_d   = '0;
                ch_d    = ch_q + CH_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        adc_cs_n = (state_q == ST_IDLE) || (state_q == ST_GAP);
        eng_load = (state_q == ST_SETUP);
        eng_run  = (state_q == ST_SHIFT);
        adc_sclk = eng_sclk;
        adc_mosi = eng_load ? cmd_word[SAMPLE_W-1] : eng_mosi;
    end

    always_comb begin
        data_d = data_q;
        en_d   = '0;
        if (eng_run && eng_done) begin
            data_d[ch_q] = sample_wide;
            en_d[ch_q]   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these words are architectural outputs that must read 0 after reset, so each one is reset.
            for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
            en_q <= '0;
        end else begin
            data_q <= data_d;
            en_q   <= en_d;
        end
    end

    assign data_out0 = data_q[0];
    assign data_out1 = data_q[1];
    assign data_out2 = data_q[2];
    assign data_out3 = data_q[3];
    assign data0_en  = en_q[0];
    assign data1_en  = en_q[1];
    assign data2_en  = en_q[2];
    assign data3_en  = en_q[3];

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture with a behavioural 4-channel ADC and SPI pin monitors.
module tb_adc_spi_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        scan_en = 1'b0;
    logic        adc_sclk, adc_cs_n, adc_mosi, adc_miso;
    logic [31:0] data_out0, data_out1, data_out2, data_out3;
    logic        data0_en, data1_en, data2_en, data3_en, busy;

    int n_chk = 0;
    int n_err = 0;

    adc_spi_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_en   (scan_en),
        .adc_sclk  (adc_sclk),
        .adc_cs_n  (adc_cs_n),
        .adc_mosi  (adc_mosi),
        .adc_miso  (adc_miso),
        .data_out0 (data_out0),
        .data_out1 (data_out1),
        .data_out2 (data_out2),
        .data_out3 (data_out3),
        .data0_en  (data0_en),
        .data1_en  (data1_en),
        .data2_en  (data2_en),
        .data3_en  (data3_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [15:0] adc_word [4] = '{16'h1234, 16'h8001, 16'h00FF, 16'hFFFF};
`ifdef ADC_SIGN_EXTEND_EN
    logic [31:0] exp_tab [4] = '{32'h00001234, 32'hFFFF8001, 32'h000000FF, 32'hFFFFFFFF};
`else
    logic [31:0] exp_tab [4] = '{32'h00001234, 32'h00008001, 32'h000000FF, 32'h0000FFFF};
`endif

    logic [31:0] dout [4];
    logic [3:0]  en;
    assign dout[0] = data_out0;
    assign dout[1] = data_out1;
    assign dout[2] = data_out2;
    assign dout[3] = data_out3;
    assign en = {data3_en, data2_en, data1_en, data0_en};

    // ADC model: the bench's own channel expectation selects the word; bits go out MSB first.
    logic [1:0]  exp_ch = 2'd0;
    int          adc_bit = 0;
    logic [15:0] cmd_sh = '0;
    assign adc_miso = (adc_bit < 16) ? adc_word[exp_ch][15 - adc_bit] : 1'b0;

    always @(negedge adc_cs_n) begin
        adc_bit = 0;
        cmd_sh  = '0;
    end

    always @(posedge adc_sclk) begin
        adc_bit++;
        cmd_sh = {cmd_sh[14:0], adc_mosi};
        if (rst_n && adc_bit == 2) check("cmd_ch_early", 32'(cmd_sh[1:0]), 32'(exp_ch));
    end

    // Pin and strobe monitor, sampled on the falling clk edge.
    logic        prev_sclk = 1'b0;
    int          run_len = 0;
    int          rises = 0;
    int          cs_hi_run = 0;
    bit          had_frame = 0;
    logic [1:0]  exp_sch = 2'd0;
    logic [31:0] shadow [4] = '{default: 32'h0};
    int          strobe_cnt [4] = '{default: 0};
    int          strobe_seen = 0;
    int          last_ch = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sclk = 1'b0; run_len = 0; rises = 0; cs_hi_run = 0; had_frame = 0;
            exp_ch = 2'd0; exp_sch = 2'd0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] = 32'h0;
                strobe_cnt[i] = 0;
            end
        end else begin
            if (adc_sclk != prev_sclk) begin
                if (!adc_sclk)     check("sclk_high_len", run_len, 4);
                else if (rises > 0) check("sclk_low_len", run_len, 4);
                if (adc_sclk) rises++;
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_sclk = adc_sclk;

            if (adc_cs_n) begin
                if (cs_hi_run == 0 && had_frame) begin
                    check("frame_rises", rises, 16);
                    check("cmd_word", 32'(cmd_sh), 32'({exp_ch, 14'b0}));
                    exp_ch = exp_ch + 2'd1;
                end
                cs_hi_run++;
                rises = 0;
            end else begin
                if (cs_hi_run > 0 && had_frame) check("cs_gap_ge8", 32'(cs_hi_run >= 8), 1);
                cs_hi_run = 0;
                had_frame = 1;
            end

            if (|en) begin
                check("strobe_onehot", $countones(en), 1);
                for (int n = 0; n < 4; n++) begin
                    if (en[n]) begin
                        check("strobe_order", n, 32'(exp_sch));
                        check("strobe_data", dout[n], exp_tab[n]);
                        shadow[n] = exp_tab[n];
                        strobe_cnt[n]++;
                        last_ch = n;
                    end else begin
                        check("data_held", dout[n], shadow[n]);
                    end
                end
                exp_sch = exp_sch + 2'd1;
                strobe_seen++;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic wait_strobe(output int ch, output int at);
        int base;
        base = strobe_seen;
        ch = -1;
        at = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (strobe_seen != base) begin
                ch = last_ch;
                at = cyc;
                return;
            end
        end
        check("strobe_timeout", 0, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sclk"}, 32'(adc_sclk), 0);
        check({tag, "_cs_n"}, 32'(adc_cs_n), 1);
        check({tag, "_mosi"}, 32'(adc_mosi), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_en"}, 32'(en), 0);
        for (int i = 0; i < 4; i++) check({tag, "_dout"}, dout[i], 32'h0);
    endtask

    int ch, t_prev, t_now, base;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("idle_wait_busy", 32'(busy), 0);

        // Full scan: strobes in order, one frame period apart.
        scan_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_strobe(ch, t_now);
            check("scan_ch", ch, i);
            if (i > 0) check("frame_period", t_now - t_prev, 144);
            t_prev = t_now;
        end
        for (int i = 0; i < 4; i++) check("scan_dout", dout[i], exp_tab[i]);

        // Drop scan_en mid-SHIFT of ch1: its strobe still fires, then IDLE.
        wait_strobe(ch, t_now);
        check("pre_stop_ch", ch, 0);
        repeat (40) @(negedge clk);
        scan_en = 1'b0;
        wait_strobe(ch, t_now);
        check("stop_ch", ch, 1);
        repeat (14) @(negedge clk);
        #1 check("stop_busy", 32'(busy), 0);
        check("stop_cs_n", 32'(adc_cs_n), 1);
        base = strobe_seen;
        repeat (60) @(negedge clk);
        check("idle_no_strobe", strobe_seen, base);

        // Resume addresses ch2; reset lands mid-SHIFT of that frame.
        scan_en = 1'b1;
        for (int i = 0; i < 100 && adc_cs_n; i++) @(negedge clk);
        check("resume_cs_low", 32'(adc_cs_n), 0);
        repeat (40) @(negedge clk);
        check("resume_exp_ch", 32'(exp_ch), 2);
        rst_n = 1'b0;
        #1 check_reset_state("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Ten full scans from ch0 after reset.
        for (int i = 0; i < 40; i++) begin
            wait_strobe(ch, t_now);
            check("long_ch", ch, i % 4);
        end
        for (int n = 0; n < 4; n++) check("strobe_count", strobe_cnt[n], 10);

        scan_en = 1'b0;
        repeat (200) @(negedge clk);
        #1 check("final_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
